scariv_rob_head_tracker: RTL and testbench
==========================================

SCARIV_ROB_HEAD_TRACKER -- requirements
Module: scariv_rob_head_tracker

Interface
REQ-001 SHALL have parameter CMT_ENTRY_SIZE, default 8: ROB depth, power of two.
REQ-002 SHALL have parameter DISP_SIZE, default 4: lanes per group; grp_id is a one-hot/mask of this width.
REQ-003 SHALL have parameter DONE_PORTS, default 3: number of completion report ports.
REQ-004 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_disp_valid  in  1  allocate one ROB entry this cycle.
REQ-007 i_disp_grp_valid  in  DISP_SIZE  lanes present in the dispatched group; nonzero when i_disp_valid.
REQ-008 o_disp_ready  out  1  allocation accepted this cycle.
REQ-009 o_disp_cmt_id  out  log2(CMT_ENTRY_SIZE)+1  cmt_id given to the dispatched group (tail pointer, MSB = wrap bit).
REQ-010 i_done_valid[DONE_PORTS]  in  1  completion report per port.
REQ-011 i_done_cmt_id[DONE_PORTS]  in  cmt_id_t  entry being completed.
REQ-012 i_done_grp_id[DONE_PORTS]  in  DISP_SIZE  one-hot lane being completed.
REQ-013 i_done_upd_pc[DONE_PORTS], i_done_except[DONE_PORTS]  in  1 each  completing lane redirects PC / raises exception.
REQ-014 rob_info_if.master  out  --  drives cmt_id, grp_id, done_grp_id, upd_pc_valid, except_valid (each DISP_SIZE wide except cmt_id) for the head entry.
REQ-015 o_commit_valid  out  1  head entry commits this cycle.
REQ-016 o_commit_cmt_id / o_commit_grp_id  out  cmt_id_t / DISP_SIZE  committing entry id and its lane mask.
REQ-017 o_commit_flush  out  1  committing entry contains an exception or PC update; pipeline flush.

Function
REQ-018 Head and tail pointers SHALL be cmt_id_t with wrap bit; empty when equal; full when index bits equal and wrap bits differ.
REQ-019 o_disp_ready SHALL be ~full & ~o_commit_flush; i_disp_valid & o_disp_ready writes entry at tail (grp_valid = i_disp_grp_valid; done, upd_pc, except masks cleared) and increments tail at the next edge.
REQ-020 An entry written at cycle N SHALL accept done reports from cycle N+1.
REQ-021 Each i_done_valid SHALL OR i_done_grp_id into the done mask of the entry at i_done_cmt_id index, and into upd_pc/except masks when the respective flag is set; multiple ports hitting one entry in one cycle SHALL all merge.
REQ-022 Done reports to an invalid entry SHALL be ignored.
REQ-023 rob_info_if fields SHALL reflect registered head-entry state combinationally: done at cycle N is visible at N+1.
REQ-024 rob_info_if.cmt_id SHALL equal head; when empty, grp_id, done_grp_id, upd_pc_valid and except_valid SHALL be 0.
REQ-025 o_commit_valid SHALL assert when the head is valid and done mask == grp_valid mask; head increments at the next edge.
REQ-026 o_commit_flush SHALL equal o_commit_valid & |(upd_pc | except) of the head.
REQ-027 On flush, all entries SHALL invalidate and tail SHALL be set to head+1 at the next edge, alongside the head increment.
REQ-028 When dispatch and non-flushing commit occur in the same cycle while full, dispatch SHALL be refused, because o_disp_ready uses registered full.
REQ-029 Pointer increments SHALL wrap modulo 2*CMT_ENTRY_SIZE, toggling the wrap bit.

Reset
REQ-030 While i_reset is high: head = tail = 0, all entries invalid, all masks 0.
REQ-031 Reset values SHALL be: o_disp_ready=1, o_disp_cmt_id=0, o_commit_valid=0, o_commit_flush=0, rob_info fields 0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight entries without issuing a commit.

Structure
REQ-033 cmt_id_t, grp_id_t, CMT_ENTRY_SIZE and DISP_SIZE SHALL live in scariv_pkg.
REQ-034 Per-entry storage and done merging SHALL be the sub-module scariv_rob_head_entry, instantiated CMT_ENTRY_SIZE times.

Verification
REQ-035 Dispatch grp 4'b0011 at cmt_id 0 -> done lanes 0 and 1 on two ports in one cycle -> next cycle done_grp_id=4'b0011 and o_commit_valid=1 with cmt_id 0.
REQ-036 Dispatch 8 groups without done -> o_disp_ready=0 and tail cmt_id=4'b1000; commit head -> o_disp_ready=1 one cycle later.
REQ-037 Head grp 4'b0111, lane 1 done with except -> after lanes 0 and 2 done, o_commit_flush=1 -> next cycle all entries empty and tail=head.
REQ-038 Run 20 allocate/commit cycles -> cmt_id wrap bit toggles at 8 and 16; commits stay in order.
REQ-039 Done report to an unallocated cmt_id 5 -> no state change; assert reset with 3 entries live -> no commit, empty state.

Source files
------------

// File: rtl/scariv_pkg.sv
// Shared configuration and types for the ROB head tracker.
package scariv_pkg;

    localparam int CMT_ENTRY_SIZE = 8;
    localparam int DISP_SIZE      = 4;
    localparam int DONE_PORTS     = 3;
    localparam int CMT_ID_W       = $clog2(CMT_ENTRY_SIZE) + 1;

    // cmt_id: entry index in the low bits, lap (wrap) bit in the MSB
    typedef logic [CMT_ID_W-1:0]  cmt_id_t;
    typedef logic [DISP_SIZE-1:0] grp_id_t;

endpackage

// File: rtl/rob_info_if.sv
// Head-entry status bundle published by the ROB head tracker.
interface rob_info_if #(
    parameter int CMT_ID_W  = 4,
    parameter int DISP_SIZE = 4
);
    logic [CMT_ID_W-1:0]  cmt_id;
    logic [DISP_SIZE-1:0] grp_id;
    logic [DISP_SIZE-1:0] done_grp_id;
    logic [DISP_SIZE-1:0] upd_pc_valid;
    logic [DISP_SIZE-1:0] except_valid;

    modport master (
        output cmt_id,
        output grp_id,
        output done_grp_id,
        output upd_pc_valid,
        output except_valid
    );

    modport slave (
        input cmt_id,
        input grp_id,
        input done_grp_id,
        input upd_pc_valid,
        input except_valid
    );
endinterface

// File: rtl/scariv_rob_head_entry.sv
// One ROB slot: lane mask written at dispatch, done/upd_pc/except masks
// merged from every completion port. The full cmt_id (lap bit included) is
// kept so that a report carrying the same index but a different lap cannot
// touch the slot.
module scariv_rob_head_entry
    import scariv_pkg::*;
#(
    parameter int ID_W    = 4,
    parameter int GRP_W   = 4,
    parameter int N_PORTS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write,
    input  logic [ID_W-1:0]  write_cmt_id,
    input  logic [GRP_W-1:0] write_grp_valid,
    input  logic             commit,
    input  logic             flush,
    input  logic             done_valid  [N_PORTS],
    input  logic [ID_W-1:0]  done_cmt_id [N_PORTS],
    input  logic [GRP_W-1:0] done_grp_id [N_PORTS],
    input  logic             done_upd_pc [N_PORTS],
    input  logic             done_except [N_PORTS],
    output logic             valid,
    output logic [GRP_W-1:0] grp_valid,
    output logic [GRP_W-1:0] done_grp,
    output logic [GRP_W-1:0] upd_pc,
    output logic [GRP_W-1:0] except_grp
);

    logic [ID_W-1:0]  cmt_id;
    logic [GRP_W-1:0] hit_done;
    logic [GRP_W-1:0] hit_upd;
    logic [GRP_W-1:0] hit_exc;

    // OR together every completion aimed at this live slot this cycle
    always_comb begin
        hit_done = '0;
        hit_upd  = '0;
        hit_exc  = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (done_valid[p] && valid && (done_cmt_id[p] == cmt_id)) begin
                hit_done = hit_done | done_grp_id[p];
                if (done_upd_pc[p]) hit_upd = hit_upd | done_grp_id[p];
                if (done_except[p]) hit_exc = hit_exc | done_grp_id[p];
            end
        end
    end

    // slot state: flush beats everything, a new dispatch clears the masks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid      <= 1'b0;
            cmt_id     <= '0;
            grp_valid  <= '0;
            done_grp   <= '0;
            upd_pc     <= '0;
            except_grp <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else begin
            if (commit) begin
                valid <= 1'b0;
            end
            if (write) begin
                valid      <= 1'b1;
                cmt_id     <= write_cmt_id;
                grp_valid  <= write_grp_valid;
                done_grp   <= '0;
                upd_pc     <= '0;
                except_grp <= '0;
            end else begin
                done_grp   <= done_grp | hit_done;
                upd_pc     <= upd_pc | hit_upd;
                except_grp <= except_grp | hit_exc;
            end
        end
    end

endmodule

// File: rtl/scariv_rob_head_tracker.sv
// ROB head/tail tracking: allocates one entry per dispatched group, collects
// per-lane completions and commits the head once every lane is done. A
// committing head that carries a PC update or exception flushes the ROB.
module scariv_rob_head_tracker #(
    parameter int CMT_ENTRY_SIZE = scariv_pkg::CMT_ENTRY_SIZE,
    parameter int DISP_SIZE      = scariv_pkg::DISP_SIZE,
    parameter int DONE_PORTS     = scariv_pkg::DONE_PORTS
) (
    input  logic                              i_clk,
    input  logic                              i_reset,

    input  logic                              i_disp_valid,
    input  logic [DISP_SIZE-1:0]              i_disp_grp_valid,
    output logic                              o_disp_ready,
    output logic [$clog2(CMT_ENTRY_SIZE):0]   o_disp_cmt_id,

    input  logic                              i_done_valid  [DONE_PORTS],
    input  logic [$clog2(CMT_ENTRY_SIZE):0]   i_done_cmt_id [DONE_PORTS],
    input  logic [DISP_SIZE-1:0]              i_done_grp_id [DONE_PORTS],
    input  logic                              i_done_upd_pc [DONE_PORTS],
    input  logic                              i_done_except [DONE_PORTS],

    rob_info_if.master                        rob_info,

    output logic                              o_commit_valid,
    output logic [$clog2(CMT_ENTRY_SIZE):0]   o_commit_cmt_id,
    output logic [DISP_SIZE-1:0]              o_commit_grp_id,
    output logic                              o_commit_flush
);

    localparam int IDX_W = $clog2(CMT_ENTRY_SIZE);
    localparam int ID_W  = IDX_W + 1;

    logic [ID_W-1:0]      head;
    logic [ID_W-1:0]      tail;
    logic [ID_W-1:0]      head_inc;
    logic [ID_W-1:0]      tail_inc;
    logic                 full;
    logic                 disp_fire;

    logic                 ent_valid  [CMT_ENTRY_SIZE];
    logic [DISP_SIZE-1:0] ent_grp    [CMT_ENTRY_SIZE];
    logic [DISP_SIZE-1:0] ent_done   [CMT_ENTRY_SIZE];
    logic [DISP_SIZE-1:0] ent_upd    [CMT_ENTRY_SIZE];
    logic [DISP_SIZE-1:0] ent_exc    [CMT_ENTRY_SIZE];

    logic                 h_valid;
    logic [DISP_SIZE-1:0] h_grp;
    logic [DISP_SIZE-1:0] h_done;
    logic [DISP_SIZE-1:0] h_upd;
    logic [DISP_SIZE-1:0] h_exc;

    // pointer arithmetic wraps naturally at 2*CMT_ENTRY_SIZE, flipping the lap bit
    assign head_inc = head + ID_W'(1);
    assign tail_inc = tail + ID_W'(1);

    assign full = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);

    // head slot view; every field reads as zero when the ROB is empty
    assign h_valid = ent_valid[head[IDX_W-1:0]];
    assign h_grp   = h_valid ? ent_grp[head[IDX_W-1:0]]  : '0;
    assign h_done  = h_valid ? ent_done[head[IDX_W-1:0]] : '0;
    assign h_upd   = h_valid ? ent_upd[head[IDX_W-1:0]]  : '0;
    assign h_exc   = h_valid ? ent_exc[head[IDX_W-1:0]]  : '0;

    assign o_commit_valid  = h_valid && (h_done == h_grp);
    assign o_commit_flush  = o_commit_valid && ((h_upd | h_exc) != '0);
    assign o_commit_cmt_id = head;
    assign o_commit_grp_id = h_grp;

    // readiness uses the registered full flag, so a same-cycle commit does
    // not free a slot for dispatch until the following cycle
    assign o_disp_ready  = !full && !o_commit_flush;
    assign o_disp_cmt_id = tail;
    assign disp_fire     = i_disp_valid && o_disp_ready;

    assign rob_info.cmt_id       = head;
    assign rob_info.grp_id       = h_grp;
    assign rob_info.done_grp_id  = h_done;
    assign rob_info.upd_pc_valid = h_upd;
    assign rob_info.except_valid = h_exc;

    // head advances on every commit; a flush leaves tail one past the old head,
    // which equals the new head, so the ROB comes out empty
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (o_commit_valid) begin
                head <= head_inc;
            end
            if (o_commit_flush) begin
                tail <= head_inc;
            end else if (disp_fire) begin
                tail <= tail_inc;
            end
        end
    end

    for (genvar e = 0; e < CMT_ENTRY_SIZE; e++) begin : g_entry
        logic wr_sel;
        logic cm_sel;

        assign wr_sel = disp_fire && (tail[IDX_W-1:0] == IDX_W'(e));
        assign cm_sel = o_commit_valid && (head[IDX_W-1:0] == IDX_W'(e));

        scariv_rob_head_entry #(
            .ID_W    (ID_W),
            .GRP_W   (DISP_SIZE),
            .N_PORTS (DONE_PORTS)
        ) u_entry (
            .clk             (i_clk),
            .rst             (i_reset),
            .write           (wr_sel),
            .write_cmt_id    (tail),
            .write_grp_valid (i_disp_grp_valid),
            .commit          (cm_sel),
            .flush           (o_commit_flush),
            .done_valid      (i_done_valid),
            .done_cmt_id     (i_done_cmt_id),
            .done_grp_id     (i_done_grp_id),
            .done_upd_pc     (i_done_upd_pc),
            .done_except     (i_done_except),
            .valid           (ent_valid[e]),
            .grp_valid       (ent_grp[e]),
            .done_grp        (ent_done[e]),
            .upd_pc          (ent_upd[e]),
            .except_grp      (ent_exc[e])
        );
    end

endmodule

// File: tb/tb_scariv_rob_head_tracker.sv
// Self-checking bench for scariv_rob_head_tracker: directed scenarios plus a
// randomized run against a queue-based model of the ROB.
module tb_scariv_rob_head_tracker;
    import scariv_pkg::*;

    localparam int NENT = CMT_ENTRY_SIZE;
    localparam int NP   = DONE_PORTS;
    localparam int IDM  = 2 * CMT_ENTRY_SIZE;

    typedef struct packed {
        grp_id_t grp;
        grp_id_t done;
        grp_id_t upd;
        grp_id_t exc;
    } ent_t;

    logic    clk = 1'b0;
    logic    rst;
    logic    disp_valid;
    grp_id_t disp_grp;
    logic    disp_ready;
    cmt_id_t disp_cmt_id;
    logic    done_valid  [NP];
    cmt_id_t done_cmt_id [NP];
    grp_id_t done_grp    [NP];
    logic    done_upd    [NP];
    logic    done_exc    [NP];
    logic    commit_valid;
    cmt_id_t commit_cmt_id;
    grp_id_t commit_grp;
    logic    commit_flush;

    int total = 0;
    int bad   = 0;

    rob_info_if #(.CMT_ID_W(CMT_ID_W), .DISP_SIZE(DISP_SIZE)) rob_info ();

    scariv_rob_head_tracker #(
        .CMT_ENTRY_SIZE (CMT_ENTRY_SIZE),
        .DISP_SIZE      (DISP_SIZE),
        .DONE_PORTS     (DONE_PORTS)
    ) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_disp_valid     (disp_valid),
        .i_disp_grp_valid (disp_grp),
        .o_disp_ready     (disp_ready),
        .o_disp_cmt_id    (disp_cmt_id),
        .i_done_valid     (done_valid),
        .i_done_cmt_id    (done_cmt_id),
        .i_done_grp_id    (done_grp),
        .i_done_upd_pc    (done_upd),
        .i_done_except    (done_exc),
        .rob_info         (rob_info),
        .o_commit_valid   (commit_valid),
        .o_commit_cmt_id  (commit_cmt_id),
        .o_commit_grp_id  (commit_grp),
        .o_commit_flush   (commit_flush)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_done();
        for (int p = 0; p < NP; p++) begin
            done_valid[p]  = 1'b0;
            done_cmt_id[p] = '0;
            done_grp[p]    = '0;
            done_upd[p]    = 1'b0;
            done_exc[p]    = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        disp_valid = 1'b0;
        disp_grp   = '0;
        clear_done();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        disp_valid = 1'b0;
        disp_grp   = '0;
        clear_done();
        tick();
        tick();
        total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", disp_ready); end
        total++; if (disp_cmt_id !== 4'd0) begin bad++; $display("FAIL reset_disp_id got=%0h want=0", disp_cmt_id); end
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL reset_commit got=%b want=0", commit_valid); end
        total++; if (commit_flush !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b want=0", commit_flush); end
        total++; if ({rob_info.cmt_id, rob_info.grp_id, rob_info.done_grp_id, rob_info.upd_pc_valid, rob_info.except_valid} !== 20'h0)
            begin bad++; $display("FAIL reset_rob_info got=%0h want=0", {rob_info.cmt_id, rob_info.grp_id, rob_info.done_grp_id, rob_info.upd_pc_valid, rob_info.except_valid}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_merge();
        do_reset();
        disp_valid = 1'b1;
        disp_grp   = 4'b0011;
        tick();
        disp_valid = 1'b0;
        total++; if (rob_info.grp_id !== 4'b0011) begin bad++; $display("FAIL merge_head_grp got=%b want=0011", rob_info.grp_id); end
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL merge_early_commit got=%b want=0", commit_valid); end
        total++; if (disp_cmt_id !== 4'd1) begin bad++; $display("FAIL merge_tail got=%0h want=1", disp_cmt_id); end
        done_valid[0] = 1'b1; done_cmt_id[0] = 4'd0; done_grp[0] = 4'b0001;
        done_valid[1] = 1'b1; done_cmt_id[1] = 4'd0; done_grp[1] = 4'b0010;
        tick();
        clear_done();
        total++; if (rob_info.done_grp_id !== 4'b0011) begin bad++; $display("FAIL merge_done_mask got=%b want=0011", rob_info.done_grp_id); end
        total++; if (commit_valid !== 1'b1) begin bad++; $display("FAIL merge_commit got=%b want=1", commit_valid); end
        total++; if (commit_cmt_id !== 4'd0) begin bad++; $display("FAIL merge_commit_id got=%0h want=0", commit_cmt_id); end
        total++; if (commit_grp !== 4'b0011) begin bad++; $display("FAIL merge_commit_grp got=%b want=0011", commit_grp); end
        total++; if (commit_flush !== 1'b0) begin bad++; $display("FAIL merge_flush got=%b want=0", commit_flush); end
        tick();
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL merge_after_commit got=%b want=0", commit_valid); end
        total++; if (rob_info.cmt_id !== 4'd1) begin bad++; $display("FAIL merge_head_adv got=%0h want=1", rob_info.cmt_id); end
        total++; if (rob_info.grp_id !== 4'b0000) begin bad++; $display("FAIL merge_empty_grp got=%b want=0", rob_info.grp_id); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < NENT; i++) begin
            total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL full_ready_early i=%0d got=%b want=1", i, disp_ready); end
            disp_valid = 1'b1;
            disp_grp   = 4'b0001;
            tick();
        end
        total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", disp_ready); end
        total++; if (disp_cmt_id !== 4'b1000) begin bad++; $display("FAIL full_tail got=%0h want=8", disp_cmt_id); end
        // dispatch held high while full, then while the head commits
        done_valid[0] = 1'b1; done_cmt_id[0] = 4'd0; done_grp[0] = 4'b0001;
        tick();
        clear_done();
        total++; if (commit_valid !== 1'b1) begin bad++; $display("FAIL full_commit got=%b want=1", commit_valid); end
        total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL full_ready_commit got=%b want=0", disp_ready); end
        tick();
        disp_valid = 1'b0;
        total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after got=%b want=1", disp_ready); end
        total++; if (disp_cmt_id !== 4'b1000) begin bad++; $display("FAIL full_refused got=%0h want=8", disp_cmt_id); end
        total++; if (rob_info.cmt_id !== 4'd1) begin bad++; $display("FAIL full_head got=%0h want=1", rob_info.cmt_id); end
    endtask

    task automatic test_flush();
        do_reset();
        disp_valid = 1'b1; disp_grp = 4'b0111; tick();
        disp_grp = 4'b0001; tick();
        tick();
        disp_valid = 1'b0;
        done_valid[0] = 1'b1; done_cmt_id[0] = 4'd0; done_grp[0] = 4'b0010; done_exc[0] = 1'b1;
        tick();
        clear_done();
        total++; if (rob_info.except_valid !== 4'b0010) begin bad++; $display("FAIL flush_exc_mask got=%b want=0010", rob_info.except_valid); end
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL flush_partial got=%b want=0", commit_valid); end
        done_valid[0] = 1'b1; done_cmt_id[0] = 4'd0; done_grp[0] = 4'b0001;
        done_valid[2] = 1'b1; done_cmt_id[2] = 4'd0; done_grp[2] = 4'b0100;
        disp_valid = 1'b1; disp_grp = 4'b1111;
        tick();
        clear_done();
        total++; if (commit_flush !== 1'b1) begin bad++; $display("FAIL flush_flag got=%b want=1", commit_flush); end
        total++; if (commit_grp !== 4'b0111) begin bad++; $display("FAIL flush_grp got=%b want=0111", commit_grp); end
        total++; if (disp_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", disp_ready); end
        tick();
        disp_valid = 1'b0;
        total++; if (rob_info.cmt_id !== 4'd1) begin bad++; $display("FAIL flush_head got=%0h want=1", rob_info.cmt_id); end
        total++; if (disp_cmt_id !== 4'd1) begin bad++; $display("FAIL flush_tail got=%0h want=1", disp_cmt_id); end
        total++; if (rob_info.grp_id !== 4'b0000) begin bad++; $display("FAIL flush_empty got=%b want=0", rob_info.grp_id); end
        total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL flush_ready_after got=%b want=1", disp_ready); end
        done_valid[0] = 1'b1; done_cmt_id[0] = 4'd1; done_grp[0] = 4'b0001;
        tick();
        clear_done();
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL flush_stale_commit got=%b want=0", commit_valid); end
        total++; if (rob_info.done_grp_id !== 4'b0000) begin bad++; $display("FAIL flush_stale_done got=%b want=0", rob_info.done_grp_id); end
    endtask

    task automatic test_back_to_back_wrap();
        int nc;
        do_reset();
        nc = 0;
        for (int c = 0; c < 24; c++) begin
            total++; if (disp_cmt_id !== cmt_id_t'(((c < 20) ? c : 20) % IDM)) begin bad++; $display("FAIL wrap_tail c=%0d got=%0h want=%0h", c, disp_cmt_id, ((c < 20) ? c : 20) % IDM); end
            if (c == 8) begin
                total++; if (disp_cmt_id[CMT_ID_W-1] !== 1'b1) begin bad++; $display("FAIL wrap_bit8 got=%b want=1", disp_cmt_id[CMT_ID_W-1]); end
            end
            if (c == 16) begin
                total++; if (disp_cmt_id[CMT_ID_W-1] !== 1'b0) begin bad++; $display("FAIL wrap_bit16 got=%b want=0", disp_cmt_id[CMT_ID_W-1]); end
            end
            total++; if (disp_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready c=%0d got=%b want=1", c, disp_ready); end
            if (commit_valid === 1'b1) begin
                total++; if (commit_cmt_id !== cmt_id_t'(nc % IDM)) begin bad++; $display("FAIL wrap_order got=%0h want=%0h", commit_cmt_id, nc % IDM); end
                nc++;
            end
            disp_valid     = (c < 20);
            disp_grp       = 4'b0001;
            done_valid[0]  = (c >= 1 && c <= 20);
            done_cmt_id[0] = cmt_id_t'((c >= 1) ? (c - 1) % IDM : 0);
            done_grp[0]    = 4'b0001;
            tick();
        end
        clear_done();
        disp_valid = 1'b0;
        total++; if (nc !== 20) begin bad++; $display("FAIL wrap_count got=%0d want=20", nc); end
    endtask

    task automatic test_bad_done_and_reset();
        do_reset();
        disp_valid = 1'b1; disp_grp = 4'b0011;
        repeat (3) tick();
        disp_valid = 1'b0;
        done_valid[0] = 1'b1; done_cmt_id[0] = 4'd5; done_grp[0] = 4'b0011; done_exc[0] = 1'b1; done_upd[0] = 1'b1;
        tick();
        clear_done();
        total++; if ({rob_info.done_grp_id, rob_info.except_valid, rob_info.upd_pc_valid} !== 12'h0) begin bad++; $display("FAIL bad_done_masks got=%0h want=0", {rob_info.done_grp_id, rob_info.except_valid, rob_info.upd_pc_valid}); end
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL bad_done_commit got=%b want=0", commit_valid); end
        total++; if (disp_cmt_id !== 4'd3) begin bad++; $display("FAIL bad_done_tail got=%0h want=3", disp_cmt_id); end
        for (int p = 0; p < NP; p++) begin
            done_valid[p] = 1'b1; done_cmt_id[p] = cmt_id_t'(p); done_grp[p] = 4'b0011;
        end
        tick();
        clear_done();
        total++; if (commit_valid !== 1'b1) begin bad++; $display("FAIL prerst_commit got=%b want=1", commit_valid); end
        rst = 1'b1;
        #1;
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL rst_async_commit got=%b want=0", commit_valid); end
        total++; if (disp_cmt_id !== 4'd0) begin bad++; $display("FAIL rst_async_tail got=%0h want=0", disp_cmt_id); end
        tick();
        rst = 1'b0;
        tick();
        total++; if (rob_info.grp_id !== 4'b0000) begin bad++; $display("FAIL rst_empty got=%b want=0", rob_info.grp_id); end
        done_valid[0] = 1'b1; done_cmt_id[0] = 4'd1; done_grp[0] = 4'b0011;
        tick();
        clear_done();
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL rst_no_commit got=%b want=0", commit_valid); end
    endtask

    task automatic test_random();
        ent_t    q[$];
        ent_t    e;
        int      head_m;
        int      off;
        int      lane;
        logic    exp_cv, exp_fl, exp_rdy;
        grp_id_t exp_grp, exp_done, exp_upd, exp_exc;
        do_reset();
        head_m = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            exp_grp  = (q.size() > 0) ? q[0].grp  : '0;
            exp_done = (q.size() > 0) ? q[0].done : '0;
            exp_upd  = (q.size() > 0) ? q[0].upd  : '0;
            exp_exc  = (q.size() > 0) ? q[0].exc  : '0;
            exp_cv   = (q.size() > 0) && (exp_done == exp_grp);
            exp_fl   = exp_cv && ((exp_upd | exp_exc) != '0);
            exp_rdy  = (q.size() < NENT) && !exp_fl;
            total++; if (commit_valid !== exp_cv) begin bad++; $display("FAIL rnd_commit cyc=%0d got=%b want=%b", cyc, commit_valid, exp_cv); end
            total++; if (commit_flush !== exp_fl) begin bad++; $display("FAIL rnd_flush cyc=%0d got=%b want=%b", cyc, commit_flush, exp_fl); end
            total++; if (disp_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, disp_ready, exp_rdy); end
            total++; if (disp_cmt_id !== cmt_id_t'((head_m + q.size()) % IDM)) begin bad++; $display("FAIL rnd_tail cyc=%0d got=%0h want=%0h", cyc, disp_cmt_id, (head_m + q.size()) % IDM); end
            total++; if (rob_info.cmt_id !== cmt_id_t'(head_m)) begin bad++; $display("FAIL rnd_head cyc=%0d got=%0h want=%0h", cyc, rob_info.cmt_id, head_m); end
            total++; if ({rob_info.grp_id, rob_info.done_grp_id, rob_info.upd_pc_valid, rob_info.except_valid} !== {exp_grp, exp_done, exp_upd, exp_exc})
                begin bad++; $display("FAIL rnd_info cyc=%0d got=%0h want=%0h", cyc, {rob_info.grp_id, rob_info.done_grp_id, rob_info.upd_pc_valid, rob_info.except_valid}, {exp_grp, exp_done, exp_upd, exp_exc}); end
            if (exp_cv) begin
                total++; if (commit_grp !== exp_grp) begin bad++; $display("FAIL rnd_commit_grp cyc=%0d got=%b want=%b", cyc, commit_grp, exp_grp); end
            end
            disp_valid = ($urandom_range(0, 9) < 6);
            disp_grp   = grp_id_t'($urandom_range(1, (1 << DISP_SIZE) - 1));
            clear_done();
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 9) < 7) begin
                    if (q.size() > 0 && $urandom_range(0, 9) < 9) begin
                        off = $urandom_range(0, q.size() - 1);
                        e   = q[off];
                        do lane = $urandom_range(0, DISP_SIZE - 1); while (e.grp[lane] !== 1'b1);
                        done_grp[p] = grp_id_t'(1 << lane);
                    end else if (q.size() < NENT) begin
                        off = $urandom_range(q.size(), NENT - 1);
                        done_grp[p] = grp_id_t'($urandom_range(1, (1 << DISP_SIZE) - 1));
                    end else begin
                        continue;
                    end
                    done_valid[p]  = 1'b1;
                    done_cmt_id[p] = cmt_id_t'((head_m + off) % IDM);
                    done_upd[p]    = ($urandom_range(0, 99) < 3);
                    done_exc[p]    = ($urandom_range(0, 99) < 3);
                end
            end
            @(posedge clk);
            for (int p = 0; p < NP; p++) begin
                if (done_valid[p]) begin
                    off = (int'(done_cmt_id[p]) - head_m + IDM) % IDM;
                    if (off < q.size()) begin
                        e      = q[off];
                        e.done = e.done | done_grp[p];
                        if (done_upd[p]) e.upd = e.upd | done_grp[p];
                        if (done_exc[p]) e.exc = e.exc | done_grp[p];
                        q[off] = e;
                    end
                end
            end
            if (exp_cv) begin
                void'(q.pop_front());
                head_m = (head_m + 1) % IDM;
                if (exp_fl) q.delete();
            end
            if (disp_valid && exp_rdy) begin
                q.push_back('{grp: disp_grp, done: '0, upd: '0, exc: '0});
            end
            #1;
        end
        clear_done();
        disp_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        disp_valid = 1'b0;
        disp_grp   = '0;
        clear_done();
        test_reset();
        test_merge();
        test_full();
        test_flush();
        test_back_to_back_wrap();
        test_bad_done_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
